// File: rtl/bound_act_pipe_if.sv
// bound_act_pipe_if
//   Streaming bus for bound_act_pipe. It carries the input beat (data and
//   per-beat config) with its valid/ready pair, and the output beat with its
//   valid/ready pair.
//
//   Signals (the names use the block's point of view):
//     i_valid, o_ready       input-side handshake
//     i_acc_bias  CH*AB_BW   packed signed inputs, channel k at [k*AB_BW +: AB_BW]
//     i_shift     SH_BW      rounding right-shift amount
//     i_mode      2          activation select
//     i_clip      D_BW-1     clip ceiling for clipped ReLU
//     o_valid, i_ready       output-side handshake
//     o_act_data  CH*D_BW    packed signed outputs, channel k at [k*D_BW +: D_BW]
//
//   Modports:
//     master  the environment (upstream producer plus downstream consumer)
//     slave   bound_act_pipe
interface bound_act_pipe_if #(
    parameter int CH    = 3,
    parameter int D_BW  = 8,
    parameter int AB_BW = 21,
    parameter int SH_BW = 4
);
    logic                  i_valid;
    logic                  o_ready;
    logic [CH*AB_BW-1:0]   i_acc_bias;
    logic [SH_BW-1:0]      i_shift;
    logic [1:0]            i_mode;
    logic [D_BW-2:0]       i_clip;
    logic                  o_valid;
    logic                  i_ready;
    logic [CH*D_BW-1:0]    o_act_data;

    modport master (
        output i_valid, i_acc_bias, i_shift, i_mode, i_clip, i_ready,
        input  o_ready, o_valid, o_act_data
    );

    modport slave (
        input  i_valid, i_acc_bias, i_shift, i_mode, i_clip, i_ready,
        output o_ready, o_valid, o_act_data
    );
endinterface

// File: rtl/bound_act_pipe.sv
// bound_act_pipe
//   Two-stage pipeline between the accumulator/bias stage and the activation
//   buffer. For each channel the block does the following:
//     S1: rounding arithmetic right-shift (round half up), then saturation to
//         D_BW signed, with a per-channel flag that records a clamp.
//     S2: activation. 00 is linear, 01 and 11 are ReLU, 10 is ReLU clipped
//         at i_clip.
//   The config (i_shift, i_mode, i_clip) is sampled with each accepted beat
//   and travels down the pipe with it. Both sides have full valid/ready
//   backpressure.
//
//   Ports:
//     clk, rst_n    clock and asynchronous active-low reset
//     bus           bound_act_pipe_if.slave, which carries the data path and
//                   both handshakes
//     i_cnt_clr     synchronous clear of both statistics counters. It has
//                   priority over a same-cycle increment.
//     o_sat_cnt     saturating count of channel results clamped in S1
//     o_zero_cnt    saturating count of channel outputs equal to zero
module bound_act_pipe #(
    parameter int CH     = 3,
    parameter int D_BW   = 8,
    parameter int AB_BW  = 21,
    parameter int SH_BW  = 4,
    parameter int CNT_BW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    bound_act_pipe_if.slave   bus,
    input  logic              i_cnt_clr,
    output logic [CNT_BW-1:0] o_sat_cnt,
    output logic [CNT_BW-1:0] o_zero_cnt
);
    // One guard bit above AB_BW holds x + 2^(sh-1) without overflow.
    localparam int W     = AB_BW + 1;
    localparam int INC_W = $clog2(CH + 1);

    localparam logic signed [W-1:0] SAT_MAX = W'((2 ** (D_BW - 1)) - 1);
    localparam logic signed [W-1:0] SAT_MIN = W'(-(2 ** (D_BW - 1)));

    // ------------------------------------------------------------------
    // Handshake / stall control
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic adv1;
    logic adv2;
    logic s2_load;

    assign adv2        = ~s2_valid | bus.i_ready;
    assign adv1        = ~s1_valid | adv2;
    assign s2_load     = adv2 & s1_valid;
    assign bus.o_ready = adv1;
    assign bus.o_valid = s2_valid;

    // ------------------------------------------------------------------
    // S1 combinational: round, shift, saturate
    // ------------------------------------------------------------------
    logic [CH*D_BW-1:0] s1_data_nxt;
    logic [CH-1:0]      s1_sat_nxt;

    for (genvar k = 0; k < CH; k++) begin : g_s1
        logic signed [W-1:0] x;
        logic signed [W-1:0] rnd;
        logic signed [W-1:0] r;
        logic                sat_hi;
        logic                sat_lo;

        assign x   = {bus.i_acc_bias[k*AB_BW + AB_BW - 1],
                      bus.i_acc_bias[k*AB_BW +: AB_BW]};
        // With a shift of zero the rounding term is zero, and >>> 0 then
        // passes x through unchanged.
        assign rnd = (bus.i_shift == '0) ? '0
                                         : (W'(1) << (bus.i_shift - 1'b1));
        assign r   = (x + rnd) >>> bus.i_shift;

        assign sat_hi = (r > SAT_MAX);
        assign sat_lo = (r < SAT_MIN);

        assign s1_data_nxt[k*D_BW +: D_BW] = sat_hi ? SAT_MAX[D_BW-1:0] :
                                             sat_lo ? SAT_MIN[D_BW-1:0] :
                                                      r[D_BW-1:0];
        assign s1_sat_nxt[k] = sat_hi | sat_lo;
    end

    // ------------------------------------------------------------------
    // S1 registers
    // ------------------------------------------------------------------
    logic [CH*D_BW-1:0] s1_data;
    logic [CH-1:0]      s1_sat;
    logic [1:0]         s1_mode;
    logic [D_BW-2:0]    s1_clip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_sat   <= '0;
            s1_mode  <= '0;
            s1_clip  <= '0;
        end else if (adv1) begin
            s1_valid <= bus.i_valid;
            if (bus.i_valid) begin
                s1_data <= s1_data_nxt;
                s1_sat  <= s1_sat_nxt;
                s1_mode <= bus.i_mode;
                s1_clip <= bus.i_clip;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2 combinational: activation
    // ------------------------------------------------------------------
    logic [CH*D_BW-1:0] act_nxt;
    logic [CH-1:0]      act_zero;

    for (genvar k = 0; k < CH; k++) begin : g_s2
        logic [D_BW-1:0] v;
        logic            neg;
        logic            above;
        logic [D_BW-1:0] a;

        assign v     = s1_data[k*D_BW +: D_BW];
        assign neg   = v[D_BW-1];
        // The clip ceiling is unsigned, so compare only the magnitude bits
        // of a value that is not negative.
        assign above = ~neg & (v[D_BW-2:0] > s1_clip);

        always_comb begin
            a = v;
            unique case (s1_mode)
                2'b00:   a = v;
                2'b10:   a = neg   ? '0 :
                             above ? {1'b0, s1_clip} : v;
                default: a = neg   ? '0 : v;
            endcase
        end

        assign act_nxt[k*D_BW +: D_BW] = a;
        assign act_zero[k]             = (a == '0);
    end

    // ------------------------------------------------------------------
    // S2 registers
    // ------------------------------------------------------------------
    logic [CH*D_BW-1:0] act_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            act_q    <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                act_q <= act_nxt;
            end
        end
    end

    assign bus.o_act_data = act_q;

    // ------------------------------------------------------------------
    // Statistics counters. They step only on an S2 load, so a beat held in
    // S2 by backpressure is counted once.
    // ------------------------------------------------------------------
    logic [INC_W-1:0]  sat_inc;
    logic [INC_W-1:0]  zero_inc;
    logic [CNT_BW:0]   sat_sum;
    logic [CNT_BW:0]   zero_sum;

    always_comb begin
        sat_inc  = '0;
        zero_inc = '0;
        for (int k = 0; k < CH; k++) begin
            sat_inc  = sat_inc  + INC_W'(s1_sat[k]);
            zero_inc = zero_inc + INC_W'(act_zero[k]);
        end
    end

    // The carry out of the sum acts as the overflow detector. This holds as
    // long as CH <= 2^CNT_BW.
    assign sat_sum  = {1'b0, o_sat_cnt}  + (CNT_BW+1)'(sat_inc);
    assign zero_sum = {1'b0, o_zero_cnt} + (CNT_BW+1)'(zero_inc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sat_cnt  <= '0;
            o_zero_cnt <= '0;
        end else if (i_cnt_clr) begin
            o_sat_cnt  <= '0;
            o_zero_cnt <= '0;
        end else if (s2_load) begin
            o_sat_cnt  <= sat_sum[CNT_BW]  ? '1 : sat_sum[CNT_BW-1:0];
            o_zero_cnt <= zero_sum[CNT_BW] ? '1 : zero_sum[CNT_BW-1:0];
        end
    end
endmodule

// File: tb/tb_bound_act_pipe.sv
// tb_bound_act_pipe
//   Directed, table-driven bench for bound_act_pipe. It uses CH=3, D_BW=8,
//   AB_BW=21, SH_BW=4 and a narrow CNT_BW=6 so that counter saturation can
//   be reached quickly.
module tb_bound_act_pipe;
    localparam int CH     = 3;
    localparam int D_BW   = 8;
    localparam int AB_BW  = 21;
    localparam int SH_BW  = 4;
    localparam int CNT_BW = 6;

    logic clk;
    logic rst_n;
    logic i_cnt_clr;
    logic [CNT_BW-1:0] o_sat_cnt;
    logic [CNT_BW-1:0] o_zero_cnt;

    bound_act_pipe_if #(.CH(CH), .D_BW(D_BW), .AB_BW(AB_BW), .SH_BW(SH_BW)) bus ();

    bound_act_pipe #(
        .CH(CH), .D_BW(D_BW), .AB_BW(AB_BW), .SH_BW(SH_BW), .CNT_BW(CNT_BW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .i_cnt_clr  (i_cnt_clr),
        .o_sat_cnt  (o_sat_cnt),
        .o_zero_cnt (o_zero_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         x0, x1, x2;
        int         sh;
        logic [1:0] mode;
        int         clip;
        int         e0, e1, e2;
        int         sat_cnt;
        int         zero_cnt;
    } vec_t;

    vec_t vecs [11];
    vec_t vsat3, vsat2, vsat3b;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CH*D_BW-1:0] pack_exp(input vec_t v);
        return {D_BW'(v.e2), D_BW'(v.e1), D_BW'(v.e0)};
    endfunction

    task automatic drive(input vec_t v);
        bus.i_acc_bias = {AB_BW'(v.x2), AB_BW'(v.x1), AB_BW'(v.x0)};
        bus.i_shift    = SH_BW'(v.sh);
        bus.i_mode     = v.mode;
        bus.i_clip     = (D_BW-1)'(v.clip);
    endtask

    // Sends one beat into an empty pipe with i_ready high. It then checks the
    // latency, the data and the cumulative counters.
    task automatic send_vec(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
        chk({tag, "_lat"}, 64'(bus.o_valid), 64'(0));
        @(negedge clk);
        chk({tag, "_valid"}, 64'(bus.o_valid), 64'(1));
        chk({tag, "_data"},  64'(bus.o_act_data), 64'(pack_exp(v)));
        chk({tag, "_satcnt"},  64'(o_sat_cnt),  64'(v.sat_cnt));
        chk({tag, "_zerocnt"}, 64'(o_zero_cnt), 64'(v.zero_cnt));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int in_idx, out_idx;
        logic held;
        logic saw_low;
        logic [CH*D_BW-1:0] held_data;

        //            x0       x1        x2     sh mode  clip  e0   e1   e2  sat zero
        vecs[0]  = '{ 291,     -100,     0,     4, 2'b00, 0,   18,  -6,  0,  0, 1 };
        vecs[1]  = '{ 5000,    -5000,    127,   0, 2'b00, 0,   127, -128,127,2, 1 };
        vecs[2]  = '{ -100,    40,       2,     2, 2'b01, 0,   0,   10,  1,  2, 2 };
        vecs[3]  = '{ -100,    40,       2,     2, 2'b11, 0,   0,   10,  1,  2, 3 };
        vecs[4]  = '{ -3,      5,        90,    0, 2'b10, 6,   0,   5,   6,  2, 4 };
        vecs[5]  = '{ 1,       -1,       3,     1, 2'b00, 0,   1,   0,   2,  2, 5 };
        vecs[6]  = '{ 1048575, -1048576, 16384, 15,2'b00, 0,   32,  -32, 1,  2, 5 };
        vecs[7]  = '{ 127,     200,      -1,    0, 2'b10, 127, 127, 127, 0,  3, 6 };
        vecs[8]  = '{ 50,      0,        -50,   0, 2'b10, 0,   0,   0,   0,  3, 9 };
        vecs[9]  = '{ -2000,   1020,     1019,  3, 2'b00, 0,   -128,127, 127,5, 9 };
        vecs[10] = '{ -5000,   300,      0,     0, 2'b01, 0,   0,   127, 0,  7, 11 };

        vsat2  = '{ 5000, 5000, 0,    0, 2'b00, 0, 127, 127, 0,   62, 1 };
        vsat3  = '{ 5000, -5000, 5000, 0, 2'b00, 0, 127, -128, 127, 63, 1 };
        vsat3b = vsat3;

        rst_n         = 1'b0;
        i_cnt_clr     = 1'b0;
        bus.i_valid   = 1'b0;
        bus.i_ready   = 1'b1;
        bus.i_acc_bias = '0;
        bus.i_shift   = '0;
        bus.i_mode    = '0;
        bus.i_clip    = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid",   64'(bus.o_valid),    64'(0));
        chk("rst_data",    64'(bus.o_act_data), 64'(0));
        chk("rst_ready",   64'(bus.o_ready),    64'(1));
        chk("rst_satcnt",  64'(o_sat_cnt),      64'(0));
        chk("rst_zerocnt", 64'(o_zero_cnt),     64'(0));

        // Single beats from the table
        for (int i = 0; i < 11; i++) begin
            send_vec(vecs[i], $sformatf("v%0d", i));
        end
        @(negedge clk);

        // Back-to-back stream of vecs[0..7], with i_ready low in cycles 3-5
        in_idx    = 0;
        out_idx   = 0;
        held      = 1'b0;
        saw_low   = 1'b0;
        held_data = '0;
        for (int c = 0; c < 60 && out_idx < 8; c++) begin
            @(negedge clk);
            bus.i_ready = !(c >= 3 && c <= 5);
            if (in_idx < 8) begin
                drive(vecs[in_idx]);
                bus.i_valid = 1'b1;
            end else begin
                bus.i_valid = 1'b0;
            end
            #1;
            if (held) begin
                chk($sformatf("stream_hold_valid_c%0d", c), 64'(bus.o_valid), 64'(1));
                chk($sformatf("stream_hold_data_c%0d", c), 64'(bus.o_act_data), 64'(held_data));
            end
            held      = bus.o_valid & ~bus.i_ready;
            held_data = bus.o_act_data;
            if (bus.o_valid && bus.i_ready) begin
                chk($sformatf("stream_out%0d", out_idx), 64'(bus.o_act_data),
                    64'(pack_exp(vecs[out_idx])));
                out_idx++;
            end
            if (!bus.o_ready) saw_low = 1'b1;
            if (bus.i_valid && bus.o_ready) in_idx++;
        end
        chk("stream_all_out",    64'(out_idx), 64'(8));
        chk("stream_ready_fell", 64'(saw_low), 64'(1));
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("stream_no_dup", 64'(bus.o_valid), 64'(0));

        // Counter clear, then saturation
        i_cnt_clr = 1'b1;
        @(negedge clk);
        i_cnt_clr = 1'b0;
        chk("clr_satcnt",  64'(o_sat_cnt),  64'(0));
        chk("clr_zerocnt", 64'(o_zero_cnt), 64'(0));

        drive('{5000, 5000, 5000, 0, 2'b00, 0, 0, 0, 0, 0, 0});
        bus.i_valid = 1'b1;
        repeat (20) @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_satcnt",  64'(o_sat_cnt),  64'(60));
        chk("pre_zerocnt", 64'(o_zero_cnt), 64'(0));
        send_vec(vsat2, "cnt62");
        send_vec(vsat3, "cnt_stick");
        send_vec(vsat3b, "cnt_stick2");

        // Clear in the same cycle as the S2 load of a saturating beat
        @(negedge clk);
        drive('{5000, 5000, 5000, 0, 2'b00, 0, 0, 0, 0, 0, 0});
        bus.i_valid = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
        i_cnt_clr   = 1'b1;
        @(negedge clk);
        i_cnt_clr   = 1'b0;
        chk("clrhit_valid",   64'(bus.o_valid),    64'(1));
        chk("clrhit_data",    64'(bus.o_act_data), 64'(24'h7f7f7f));
        chk("clrhit_satcnt",  64'(o_sat_cnt),      64'(0));
        chk("clrhit_zerocnt", 64'(o_zero_cnt),     64'(0));

        // Reset while the pipe is full and stalled
        @(negedge clk);
        bus.i_ready = 1'b0;
        drive(vecs[1]);
        bus.i_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("full_valid",  64'(bus.o_valid), 64'(1));
        chk("full_ready",  64'(bus.o_ready), 64'(0));
        chk("full_satcnt", 64'(o_sat_cnt),   64'(2));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid",  64'(bus.o_valid),    64'(0));
        chk("arst_data",   64'(bus.o_act_data), 64'(0));
        chk("arst_satcnt", 64'(o_sat_cnt),      64'(0));
        chk("arst_ready",  64'(bus.o_ready),    64'(1));
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst_valid_c%0d", c), 64'(bus.o_valid), 64'(0));
            chk($sformatf("post_rst_ready_c%0d", c), 64'(bus.o_ready), 64'(1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
